// File: rtl/databus_arbiter_mc.sv
// databus_arbiter_mc: command decoder and sequencer for the serial-interface cache.
// Handles register writes and readbacks, chip-ID readback, EEPROM readback,
// EEPROM-to-cache bulk load and the EEPROM program handshake.
module databus_arbiter_mc #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          NUM_REGS    = 4,
  parameter int          ADDR_WIDTH  = 4,
  parameter int          EEP_RD_LAT  = 2,
  parameter logic [15:0] CHIP_ID_REV = 16'hF002,
  localparam int         MSG_WIDTH   = 8 + 4 + ADDR_WIDTH + DATA_WIDTH + 2
) (
  input  logic                           sys_clk,
  input  logic                           porb,
  input  logic [MSG_WIDTH-1:0]           data_in,
  input  logic                           valid,
  input  logic                           en_rail_rail,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] eeprom_cache,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           p2s_en,
  output logic                           read_eep,
  output logic                           pgm_eep,
  output logic                           eep_cycleb,
  output logic                           eep_clrb,
  output logic [NUM_REGS-1:0]            reg_ldb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cache_out,
  output logic                           busy,
  output logic                           cmd_err
);

  localparam int IDX_W = $clog2(NUM_REGS + 1);
  localparam int CNT_W = 4;
  localparam logic [DATA_WIDTH-1:0] CHIP_ID_W = DATA_WIDTH'(CHIP_ID_REV);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HOLD     = 3'd1;
  localparam logic [2:0] EEP_WAIT = 3'd2;
  localparam logic [2:0] LOAD     = 3'd3;
  localparam logic [2:0] PGM_ARM  = 3'd4;
  localparam logic [2:0] PGM_RAIL = 3'd5;
  localparam logic [2:0] PGM_ON   = 3'd6;

  logic [2:0]            state;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] words [NUM_REGS];
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  op_load;

  logic [3:0]            cmd_mode;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_parity;
  logic                  unused_fields;
  logic                  parity_ok;
  logic                  mode_ok;
  logic                  needs_addr;
  logic                  addr_ok;
  logic                  cmd_good;
  logic                  valid_rise;
  logic                  exit_now;
  logic [DATA_WIDTH-1:0] reg_rd_word;
  logic [DATA_WIDTH-1:0] eep_rd_word;
  logic [DATA_WIDTH-1:0] eep_ld_word;

  // Command word fields; the preamble and end bit carry no meaning here.
  assign cmd_data      = data_in[DATA_WIDTH+1:2];
  assign cmd_addr      = data_in[DATA_WIDTH+2 +: ADDR_WIDTH];
  assign cmd_mode      = data_in[DATA_WIDTH+ADDR_WIDTH+2 +: 4];
  assign cmd_parity    = data_in[1];
  assign unused_fields = ^{data_in[MSG_WIDTH-1 -: 8], data_in[0]};

  assign parity_ok  = ((^{cmd_mode, cmd_addr, cmd_data}) == cmd_parity);
  assign mode_ok    = (cmd_mode <= 4'd5);
  assign needs_addr = (cmd_mode == 4'd0) || (cmd_mode == 4'd2) || (cmd_mode == 4'd3);
  assign addr_ok    = (32'(cmd_addr) < NUM_REGS);
  assign cmd_good   = parity_ok && mode_ok && (!needs_addr || addr_ok);
  assign valid_rise = valid && !valid_q;

  // Every waiting state gives up as soon as the host drops valid; LOAD is exempt.
  assign exit_now = !valid && ((state == HOLD) || (state == EEP_WAIT) ||
                               (state == PGM_ARM) || (state == PGM_RAIL) ||
                               (state == PGM_ON));

  assign busy = (state != IDLE);

  // Word selection by address/index, written as compare loops so that an
  // out-of-range address simply selects nothing.
  always_comb begin
    reg_rd_word = '0;
    eep_rd_word = '0;
    eep_ld_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == ADDR_WIDTH'(i)) reg_rd_word = words[i];
      if (addr_q == ADDR_WIDTH'(i))   eep_rd_word = eeprom_cache[i*DATA_WIDTH +: DATA_WIDTH];
      if (idx_q == IDX_W'(i))         eep_ld_word = eeprom_cache[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Flatten the cache words onto the output bus, word i at slice i.
  always_comb begin
    cache_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cache_out[i*DATA_WIDTH +: DATA_WIDTH] = words[i];
    end
  end

  // Main sequencer: command acceptance, FSM and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!porb) begin
      state      <= IDLE;
      valid_q    <= 1'b0;
      data_out   <= '0;
      p2s_en     <= 1'b0;
      read_eep   <= 1'b0;
      pgm_eep    <= 1'b0;
      eep_cycleb <= 1'b1;
      eep_clrb   <= 1'b0;
      reg_ldb    <= '0;
      cmd_err    <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      op_load    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) words[i] <= '0;
    end else begin
      valid_q  <= valid;
      eep_clrb <= ~pgm_eep;
      cmd_err  <= 1'b0;

      if (exit_now) begin
        state      <= IDLE;
        data_out   <= '0;
        p2s_en     <= 1'b0;
        read_eep   <= 1'b0;
        pgm_eep    <= 1'b0;
        eep_cycleb <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (valid_rise) begin
              if (!cmd_good) begin
                cmd_err <= 1'b1;
              end else begin
                addr_q <= cmd_addr;
                case (cmd_mode)
                  4'd0: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                      if (cmd_addr == ADDR_WIDTH'(i)) words[i] <= cmd_data;
                    end
                    state <= HOLD;
                  end
                  4'd1: begin
                    data_out <= CHIP_ID_W;
                    p2s_en   <= 1'b1;
                    state    <= HOLD;
                  end
                  4'd2: begin
                    data_out <= reg_rd_word;
                    p2s_en   <= 1'b1;
                    state    <= HOLD;
                  end
                  4'd3, 4'd4: begin
                    read_eep <= 1'b1;
                    cnt_q    <= CNT_W'(EEP_RD_LAT - 1);
                    op_load  <= (cmd_mode == 4'd4);
                    state    <= EEP_WAIT;
                  end
                  default: begin
                    eep_cycleb <= 1'b0;
                    data_out   <= '0;
                    state      <= PGM_ARM;
                  end
                endcase
              end
            end
          end

          HOLD: begin
            state <= HOLD;
          end

          EEP_WAIT: begin
            if (cnt_q == '0) begin
              if (op_load) begin
                words[0] <= eeprom_cache[DATA_WIDTH-1:0];
                data_out <= eeprom_cache[DATA_WIDTH-1:0];
                reg_ldb  <= NUM_REGS'(1);
                idx_q    <= IDX_W'(1);
                state    <= LOAD;
              end else begin
                data_out <= eep_rd_word;
                p2s_en   <= 1'b1;
                state    <= HOLD;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end

          LOAD: begin
            if (idx_q == IDX_W'(NUM_REGS)) begin
              reg_ldb  <= '0;
              data_out <= '0;
              read_eep <= 1'b0;
              state    <= IDLE;
            end else begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_q == IDX_W'(i)) words[i] <= eep_ld_word;
                reg_ldb[i] <= (idx_q == IDX_W'(i));
              end
              data_out <= eep_ld_word;
              idx_q    <= idx_q + 1'b1;
            end
          end

          PGM_ARM: begin
            if (en_rail_rail) state <= PGM_RAIL;
          end

          PGM_RAIL: begin
            if (!en_rail_rail) begin
              pgm_eep <= 1'b1;
              state   <= PGM_ON;
            end
          end

          PGM_ON: begin
            state <= PGM_ON;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end

      if ((state != IDLE) && valid_rise) cmd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_databus_arbiter_mc.sv
// tb_databus_arbiter_mc: directed, table-driven bench for databus_arbiter_mc
// with default parameters (16-bit words, 4 registers, EEPROM latency 2).
module tb_databus_arbiter_mc;

  localparam int DW  = 16;
  localparam int NR  = 4;
  localparam int AW  = 4;
  localparam int MW  = 8 + 4 + AW + DW + 2;

  logic            sys_clk = 1'b0;
  logic            porb;
  logic [MW-1:0]   data_in;
  logic            valid;
  logic            en_rail_rail;
  logic [NR*DW-1:0] eeprom_cache;
  logic [DW-1:0]   data_out;
  logic            p2s_en;
  logic            read_eep;
  logic            pgm_eep;
  logic            eep_cycleb;
  logic            eep_clrb;
  logic [NR-1:0]   reg_ldb;
  logic [NR*DW-1:0] cache_out;
  logic            busy;
  logic            cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [3:0]  mode;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        bad_par;
    logic        exp_err;
    logic        exp_busy;
    logic [15:0] exp_dout;
    logic        exp_p2s;
    logic [63:0] exp_cache;
  } vec_t;

  vec_t vq[$];

  databus_arbiter_mc #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW),
    .EEP_RD_LAT (2),
    .CHIP_ID_REV(16'hF002)
  ) dut (
    .sys_clk     (sys_clk),
    .porb        (porb),
    .data_in     (data_in),
    .valid       (valid),
    .en_rail_rail(en_rail_rail),
    .eeprom_cache(eeprom_cache),
    .data_out    (data_out),
    .p2s_en      (p2s_en),
    .read_eep    (read_eep),
    .pgm_eep     (pgm_eep),
    .eep_cycleb  (eep_cycleb),
    .eep_clrb    (eep_clrb),
    .reg_ldb     (reg_ldb),
    .cache_out   (cache_out),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Safety net in case the clocked sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [MW-1:0] mkCmd(input logic [3:0] mode, input logic [3:0] addr,
                                          input logic [15:0] data, input logic bad_par);
    logic p;
    p = (^{mode, addr, data}) ^ bad_par;
    return {8'hA5, mode, addr, data, p, 1'b1};
  endfunction

  function automatic vec_t mkVec(input string name, input logic [3:0] mode, input logic [3:0] addr,
                                 input logic [15:0] data, input logic bad_par, input logic exp_err,
                                 input logic exp_busy, input logic [15:0] exp_dout,
                                 input logic exp_p2s, input logic [63:0] exp_cache);
    vec_t v;
    v.name = name; v.mode = mode; v.addr = addr; v.data = data; v.bad_par = bad_par;
    v.exp_err = exp_err; v.exp_busy = exp_busy; v.exp_dout = exp_dout;
    v.exp_p2s = exp_p2s; v.exp_cache = exp_cache;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [MW-1:0] cmd);
    @(negedge sys_clk);
    data_in = cmd;
    valid   = 1'b1;
    tick();
  endtask

  task automatic dropValid();
    @(negedge sys_clk);
    valid = 1'b0;
    tick();
  endtask

  initial begin
    porb         = 1'b0;
    valid        = 1'b0;
    en_rail_rail = 1'b0;
    data_in      = '0;
    eeprom_cache = {16'h0004, 16'h0003, 16'h1234, 16'h0001};

    vq.push_back(mkVec("write_a2",    4'd0, 4'd2, 16'hA5A5, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 64'h0000_A5A5_0000_0000));
    vq.push_back(mkVec("readreg_a2",  4'd2, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b1, 64'h0000_A5A5_0000_0000));
    vq.push_back(mkVec("read_id",     4'd1, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hF002, 1'b1, 64'h0000_A5A5_0000_0000));
    vq.push_back(mkVec("write_a0",    4'd0, 4'd0, 16'h1357, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 64'h0000_A5A5_0000_1357));
    vq.push_back(mkVec("write_a3",    4'd0, 4'd3, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 64'hFFFF_A5A5_0000_1357));
    vq.push_back(mkVec("readreg_a3",  4'd2, 4'd3, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 64'hFFFF_A5A5_0000_1357));
    vq.push_back(mkVec("readreg_a1",  4'd2, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 64'hFFFF_A5A5_0000_1357));
    vq.push_back(mkVec("badpar_wr",   4'd0, 4'd1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 64'hFFFF_A5A5_0000_1357));
    vq.push_back(mkVec("readreg_a4",  4'd2, 4'd4, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 64'hFFFF_A5A5_0000_1357));
    vq.push_back(mkVec("bad_mode7",   4'd7, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 64'hFFFF_A5A5_0000_1357));
    vq.push_back(mkVec("write_a5",    4'd0, 4'd5, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 64'hFFFF_A5A5_0000_1357));
    vq.push_back(mkVec("readeep_a4",  4'd3, 4'd4, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 64'hFFFF_A5A5_0000_1357));
    vq.push_back(mkVec("readreg_a0",  4'd2, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1357, 1'b1, 64'hFFFF_A5A5_0000_1357));

    // Reset state
    repeat (2) tick();
    checkOutput("rst cache_out",  cache_out,  64'h0);
    checkOutput("rst data_out",   data_out,   16'h0);
    checkOutput("rst p2s_en",     p2s_en,     1'b0);
    checkOutput("rst read_eep",   read_eep,   1'b0);
    checkOutput("rst pgm_eep",    pgm_eep,    1'b0);
    checkOutput("rst eep_cycleb", eep_cycleb, 1'b1);
    checkOutput("rst eep_clrb",   eep_clrb,   1'b0);
    checkOutput("rst reg_ldb",    reg_ldb,    4'h0);
    checkOutput("rst busy",       busy,       1'b0);
    checkOutput("rst cmd_err",    cmd_err,    1'b0);
    @(negedge sys_clk);
    porb = 1'b1;
    tick();
    checkOutput("post-rst eep_clrb", eep_clrb, 1'b1);

    // Table of single-cycle commands and rejections
    foreach (vq[k]) begin
      applyStimulus(mkCmd(vq[k].mode, vq[k].addr, vq[k].data, vq[k].bad_par));
      checkOutput($sformatf("%s cmd_err", vq[k].name),   cmd_err,   vq[k].exp_err);
      checkOutput($sformatf("%s busy", vq[k].name),      busy,      vq[k].exp_busy);
      checkOutput($sformatf("%s data_out", vq[k].name),  data_out,  vq[k].exp_dout);
      checkOutput($sformatf("%s p2s_en", vq[k].name),    p2s_en,    vq[k].exp_p2s);
      checkOutput($sformatf("%s cache_out", vq[k].name), cache_out, vq[k].exp_cache);
      dropValid();
      checkOutput($sformatf("%s idle busy", vq[k].name),    busy,     1'b0);
      checkOutput($sformatf("%s idle p2s_en", vq[k].name),  p2s_en,   1'b0);
      checkOutput($sformatf("%s idle data_out", vq[k].name), data_out, 16'h0);
      checkOutput($sformatf("%s idle cmd_err", vq[k].name), cmd_err,  1'b0);
    end

    // READ_EEP addr 1 with latency 2
    applyStimulus(mkCmd(4'd3, 4'd1, 16'h0, 1'b0));
    checkOutput("reep E read_eep", read_eep, 1'b1);
    checkOutput("reep E p2s_en",   p2s_en,   1'b0);
    checkOutput("reep E busy",     busy,     1'b1);
    tick();
    checkOutput("reep E+1 p2s_en", p2s_en, 1'b0);
    tick();
    checkOutput("reep E+2 data_out", data_out, 16'h1234);
    checkOutput("reep E+2 p2s_en",   p2s_en,   1'b1);
    checkOutput("reep E+2 read_eep", read_eep, 1'b1);
    dropValid();
    checkOutput("reep exit read_eep", read_eep, 1'b0);
    checkOutput("reep exit p2s_en",   p2s_en,   1'b0);
    checkOutput("reep exit data_out", data_out, 16'h0);
    checkOutput("reep exit busy",     busy,     1'b0);

    // READ_EEP aborted by valid falling during the wait
    applyStimulus(mkCmd(4'd3, 4'd0, 16'h0, 1'b0));
    dropValid();
    checkOutput("reep abort busy",     busy,     1'b0);
    checkOutput("reep abort read_eep", read_eep, 1'b0);
    tick();
    checkOutput("reep abort p2s_en",   p2s_en,   1'b0);

    // LOAD_EEP, valid dropped and re-raised during the load
    eeprom_cache = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    applyStimulus(mkCmd(4'd4, 4'd0, 16'h0, 1'b0));
    checkOutput("load E busy",     busy,     1'b1);
    checkOutput("load E read_eep", read_eep, 1'b1);
    checkOutput("load E reg_ldb",  reg_ldb,  4'h0);
    tick();
    checkOutput("load E+1 reg_ldb", reg_ldb, 4'h0);
    tick();
    checkOutput("load E+2 reg_ldb",  reg_ldb,  4'b0001);
    checkOutput("load E+2 data_out", data_out, 16'h0001);
    @(negedge sys_clk);
    valid = 1'b0;
    tick();
    checkOutput("load E+3 reg_ldb",  reg_ldb,  4'b0010);
    checkOutput("load E+3 data_out", data_out, 16'h0002);
    @(negedge sys_clk);
    valid = 1'b1;
    tick();
    checkOutput("load E+4 reg_ldb", reg_ldb, 4'b0100);
    checkOutput("load E+4 cmd_err", cmd_err, 1'b1);
    tick();
    checkOutput("load E+5 reg_ldb",  reg_ldb,  4'b1000);
    checkOutput("load E+5 data_out", data_out, 16'h0004);
    checkOutput("load E+5 cmd_err",  cmd_err,  1'b0);
    checkOutput("load E+5 busy",     busy,     1'b1);
    tick();
    checkOutput("load done busy",      busy,      1'b0);
    checkOutput("load done reg_ldb",   reg_ldb,   4'h0);
    checkOutput("load done data_out",  data_out,  16'h0);
    checkOutput("load done read_eep",  read_eep,  1'b0);
    checkOutput("load done cache_out", cache_out, 64'h0004_0003_0002_0001);
    dropValid();
    checkOutput("load idle busy", busy, 1'b0);

    // Reset in the middle of a LOAD
    eeprom_cache = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
    applyStimulus(mkCmd(4'd4, 4'd0, 16'h0, 1'b0));
    repeat (3) tick();
    checkOutput("midload cache_out", cache_out, 64'h0004_0003_0006_0005);
    @(negedge sys_clk);
    porb = 1'b0;
    tick();
    checkOutput("midrst cache_out", cache_out, 64'h0);
    checkOutput("midrst busy",      busy,      1'b0);
    checkOutput("midrst reg_ldb",   reg_ldb,   4'h0);
    checkOutput("midrst read_eep",  read_eep,  1'b0);
    @(negedge sys_clk);
    porb  = 1'b1;
    valid = 1'b0;
    tick();
    checkOutput("midrst after busy", busy, 1'b0);

    // PGM with the full rail handshake
    applyStimulus(mkCmd(4'd5, 4'd0, 16'h0, 1'b0));
    checkOutput("pgm E busy",     busy,     1'b1);
    checkOutput("pgm E pgm_eep",  pgm_eep,  1'b0);
    checkOutput("pgm E data_out", data_out, 16'h0);
    tick();
    checkOutput("pgm E+1 eep_cycleb", eep_cycleb, 1'b0);
    checkOutput("pgm E+1 pgm_eep",    pgm_eep,    1'b0);
    @(negedge sys_clk);
    en_rail_rail = 1'b1;
    tick();
    checkOutput("pgm rail-hi pgm_eep", pgm_eep, 1'b0);
    @(negedge sys_clk);
    en_rail_rail = 1'b0;
    tick();
    checkOutput("pgm rail-lo pgm_eep",  pgm_eep,  1'b1);
    checkOutput("pgm rail-lo eep_clrb", eep_clrb, 1'b1);
    tick();
    checkOutput("pgm on eep_clrb", eep_clrb, 1'b0);
    checkOutput("pgm on pgm_eep",  pgm_eep,  1'b1);
    dropValid();
    checkOutput("pgm exit pgm_eep",    pgm_eep,    1'b0);
    checkOutput("pgm exit eep_cycleb", eep_cycleb, 1'b1);
    checkOutput("pgm exit busy",       busy,       1'b0);
    tick();
    checkOutput("pgm exit eep_clrb", eep_clrb, 1'b1);

    // PGM with the rail already high at acceptance
    en_rail_rail = 1'b1;
    applyStimulus(mkCmd(4'd5, 4'd3, 16'h1111, 1'b0));
    tick();
    checkOutput("pgmfast E+1 pgm_eep", pgm_eep, 1'b0);
    @(negedge sys_clk);
    en_rail_rail = 1'b0;
    tick();
    checkOutput("pgmfast E+2 pgm_eep", pgm_eep, 1'b1);
    dropValid();
    checkOutput("pgmfast exit pgm_eep", pgm_eep, 1'b0);
    checkOutput("pgmfast exit busy",    busy,    1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
